// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier:
// FSM state encoding and the default operand width.
package mult_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } mult_state_e;

endpackage

// File: rtl/mult_step.sv
// One combinational shift-add iteration of the multiplier.
// The carry out of the upper-half add becomes the new accumulator MSB.
module mult_step
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   mag_a_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0] addend;
    logic [WIDTH:0] sum;

    always_comb begin
        addend = acc_i[0] ? {1'b0, mag_a_i} : '0;
        sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + addend;
        acc_o  = {sum, acc_i[WIDTH-1:1]};
    end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential WIDTH x WIDTH multiplier, signed or unsigned, on a magnitude
// shift-add datapath. One result every WIDTH+2 cycles.
//
// state   | meaning
// IDLE    | waiting for start; operands captured on accept
// CALC    | WIDTH shift-add steps, one per clock
// FIN     | sign fix-up, product register load, done pulse
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
    localparam logic [2*WIDTH-1:0] ONE = {{(2*WIDTH-1){1'b0}}, 1'b1};

    mult_state_e          state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mag_a_q, mag_a_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 done_q, done_d;

    logic [WIDTH-1:0]     mag_a_in, mag_b_in;
    logic [2*WIDTH-1:0]   acc_step;

    mult_step #(.WIDTH(WIDTH)) u_step (
        .acc_i   (acc_q),
        .mag_a_i (mag_a_q),
        .acc_o   (acc_step)
    );

    // -2^(WIDTH-1) negates to itself, which read unsigned is the right magnitude.
    always_comb begin
        mag_a_in = (signed_mode && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
        mag_b_in = (signed_mode && multiplier[WIDTH-1])   ? -multiplier   : multiplier;
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mag_a_d   = mag_a_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        product_d = product_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mag_a_d = mag_a_in;
                    acc_d   = {{WIDTH{1'b0}}, mag_b_in};
                    cnt_d   = '0;
                    neg_d   = signed_mode & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                acc_d = acc_step;
                if (cnt_q == LAST_STEP) begin
                    state_d = ST_FIN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_FIN: begin
                product_d = neg_q ? (~acc_q + ONE) : acc_q;
                done_d    = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            mag_a_q   <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mag_a_q   <= mag_a_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier at WIDTH=8: directed corner cases,
// random operands against an arithmetic reference, and control scenarios.
module tb_seq_multiplier;

    localparam int W = 8;
    localparam int LAT = W + 1;

    logic           clk = 1'b0;
    logic           Reset = 1'b1;
    logic           start = 1'b0;
    logic           signed_mode = 1'b0;
    logic [W-1:0]   multiplicand = '0;
    logic [W-1:0]   multiplier = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int pass_cnt = 0;
    int total_cnt = 0;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk          (clk),
        .Reset        (Reset),
        .start        (start),
        .signed_mode  (signed_mode),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic s);
        longint sa, sb;
        sa = s ? longint'($signed(a)) : longint'(a);
        sb = s ? longint'($signed(b)) : longint'(b);
        return (2*W)'(sa * sb);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one operation and returns in the done cycle (or after a bounded wait).
    // Operand inputs are scrambled while the operation runs.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          output int lat);
        multiplicand = a;
        multiplier   = b;
        signed_mode  = s;
        start        = 1'b1;
        tick();
        start = 1'b0;
        lat   = 0;
        while (done !== 1'b1 && lat < 40) begin
            multiplicand = W'($urandom);
            multiplier   = W'($urandom);
            signed_mode  = 1'($urandom);
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        tick();
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy);
        else pass_cnt++;
        total_cnt++;
        if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done);
        else pass_cnt++;
        total_cnt++;
        if (product !== '0) $display("FAIL reset_product: got %h expected 0000", product);
        else pass_cnt++;
        Reset = 1'b0;
        tick();
    endtask

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic           s;
        logic [2*W-1:0] exp;
    } dir_case_t;

    task automatic test_directed();
        dir_case_t cases[$];
        int lat;
        cases.push_back('{8'd7,   8'd6,   1'b0, 16'h002A});
        cases.push_back('{8'hFF,  8'hFF,  1'b0, 16'hFE01});
        cases.push_back('{8'hFD,  8'd5,   1'b1, 16'hFFF1});
        cases.push_back('{8'h80,  8'h80,  1'b1, 16'h4000});
        cases.push_back('{8'h80,  8'h7F,  1'b1, 16'hC080});
        cases.push_back('{8'h00,  8'h80,  1'b1, 16'h0000});
        foreach (cases[i]) begin
            run_op(cases[i].a, cases[i].b, cases[i].s, lat);
            total_cnt++;
            if (lat != LAT) $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, LAT);
            else pass_cnt++;
            total_cnt++;
            if (product !== cases[i].exp)
                $display("FAIL dir%0d_product: got %h expected %h", i, product, cases[i].exp);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (done !== 1'b0) $display("FAIL dir%0d_done_width: got %b expected 0", i, done);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [W-1:0]   a, b;
        logic           s;
        logic [2*W-1:0] exp;
        int lat;
        for (int i = 0; i < 30; i++) begin
            a = (i % 5 == 0) ? 8'h80 : W'($urandom);
            b = (i % 7 == 0) ? 8'h80 : W'($urandom);
            s = 1'($urandom);
            exp = ref_mul(a, b, s);
            run_op(a, b, s, lat);
            total_cnt++;
            if (lat != LAT || product !== exp)
                $display("FAIL rand%0d: a=%h b=%h s=%b got %h lat %0d expected %h lat %0d",
                         i, a, b, s, product, lat, exp, LAT);
            else pass_cnt++;
            if (i % 3 == 0) tick();
        end
    endtask

    task automatic test_ignore_start();
        int dones = 0;
        logic [2*W-1:0] seen = '0;
        multiplicand = 8'd7;
        multiplier   = 8'd6;
        signed_mode  = 1'b0;
        start        = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL ignore_busy: got %b expected 1", busy);
        else pass_cnt++;
        multiplicand = 8'd3;
        multiplier   = 8'd3;
        start        = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (done === 1'b1) begin
                dones++;
                seen = product;
            end
            tick();
        end
        total_cnt++;
        if (dones != 1) $display("FAIL ignore_done_count: got %0d expected 1", dones);
        else pass_cnt++;
        total_cnt++;
        if (seen !== 16'h002A) $display("FAIL ignore_product: got %h expected 002A", seen);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        int lat;
        multiplicand = 8'd5;
        multiplier   = 8'd9;
        signed_mode  = 1'b0;
        start        = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        Reset = 1'b1;
        #1;
        total_cnt++;
        if (product !== '0 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL midreset_async: got product %h busy %b done %b expected 0000 0 0",
                     product, busy, done);
        else pass_cnt++;
        tick();
        Reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) dones++;
            tick();
        end
        total_cnt++;
        if (dones != 0) $display("FAIL midreset_no_done: got %0d pulses expected 0", dones);
        else pass_cnt++;
        run_op(8'd7, 8'd6, 1'b0, lat);
        total_cnt++;
        if (lat != LAT || product !== 16'h002A)
            $display("FAIL midreset_restart: got %h lat %0d expected 002A lat %0d", product, lat, LAT);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]   a1, b1, a2, b2;
        logic           s1, s2;
        logic [2*W-1:0] r1, r2;
        int lat, n;
        int held_bad = 0;
        for (int k = 0; k < 3; k++) begin
            a1 = W'($urandom); b1 = W'($urandom); s1 = 1'($urandom);
            a2 = W'($urandom); b2 = W'($urandom); s2 = 1'($urandom);
            r1 = ref_mul(a1, b1, s1);
            r2 = ref_mul(a2, b2, s2);
            if (r2 == r1) b2 = b2 ^ 8'h01;
            r2 = ref_mul(a2, b2, s2);
            run_op(a1, b1, s1, lat);
            total_cnt++;
            if (product !== r1) $display("FAIL b2b%0d_first: got %h expected %h", k, product, r1);
            else pass_cnt++;
            multiplicand = a2;
            multiplier   = b2;
            signed_mode  = s2;
            start        = 1'b1;
            tick();
            start = 1'b0;
            n = 1;
            held_bad = 0;
            while (done !== 1'b1 && n < 40) begin
                if (product !== r1) held_bad++;
                tick();
                n++;
            end
            total_cnt++;
            if (n != W + 2) $display("FAIL b2b%0d_period: got %0d expected %0d", k, n, W + 2);
            else pass_cnt++;
            total_cnt++;
            if (held_bad != 0) $display("FAIL b2b%0d_hold: got %0d changed cycles expected 0", k, held_bad);
            else pass_cnt++;
            total_cnt++;
            if (product !== r2) $display("FAIL b2b%0d_second: got %h expected %h", k, product, r2);
            else pass_cnt++;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
